// File: rtl/spawn_arbiter.sv
// rtl/spawn_arbiter.sv - round-robin arbiter sharing one spawn channel among NUM_ACCS requesters
//
// Grants the new-task channel to one requester at a time, forwards its whole
// packet, then holds the grant until the manager ACK for that packet has been
// handed back to the same requester. Fairness is per packet+ACK, so a rejected
// requester re-competes behind everyone else.
//
// Ports:
//   clk, rstn           clock, asynchronous active-low reset
//   in_valid/in_ready   per-requester spawn beat handshake
//   in_data/in_last     per-requester beat (64 bits each, requester i at [64i+63:64i])
//   out_valid/out_ready beat handshake towards the manager
//   out_data/out_last   forwarded beat, out_id = granted requester index
//   ack_in_*            ACK from the manager (code in ack_in_data[7:0], target in ack_in_dest)
//   ack_out_valid/ready per-requester ACK handshake, ack_out_data shared registered word
//   err                 sticky: an ACK arrived whose dest was not the granted requester
//
// Optional: define SPAWN_ARB_STATS_EN to add saturating counters stat_ok,
// stat_reject and stat_final for captured ACK codes.

module spawn_arbiter #(
    parameter int         NUM_ACCS   = 4,
    parameter logic [7:0] ACK_OK     = 8'h01,
    parameter logic [7:0] ACK_REJECT = 8'h00,
    parameter logic [7:0] ACK_FINAL  = 8'h02
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NUM_ACCS-1:0]      in_valid,
    output logic [NUM_ACCS-1:0]      in_ready,
    input  logic [64*NUM_ACCS-1:0]   in_data,
    input  logic [NUM_ACCS-1:0]      in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [63:0]              out_data,
    output logic                     out_last,
    output logic [7:0]               out_id,
    input  logic                     ack_in_valid,
    output logic                     ack_in_ready,
    input  logic [63:0]              ack_in_data,
    input  logic [7:0]               ack_in_dest,
    output logic [NUM_ACCS-1:0]      ack_out_valid,
    input  logic [NUM_ACCS-1:0]      ack_out_ready,
    output logic [63:0]              ack_out_data,
    output logic                     err
`ifdef SPAWN_ARB_STATS_EN
    ,
    output logic [31:0]              stat_ok,
    output logic [31:0]              stat_reject,
    output logic [31:0]              stat_final
`endif
);

    localparam int IDW = $clog2(NUM_ACCS);
    localparam logic [IDW-1:0] LAST_RST = IDW'(NUM_ACCS - 1);

    // Distinct codes keep the statistics unambiguous; out-of-range sizes would
    // break the 8-bit id and the index arithmetic.
    if (NUM_ACCS < 2 || NUM_ACCS > 16 || ACK_OK == ACK_REJECT ||
        ACK_OK == ACK_FINAL || ACK_REJECT == ACK_FINAL) begin : g_bad_cfg
        $error("spawn_arbiter: unsupported parameter set");
    end

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FWD      = 2'd1,
        WAIT_ACK = 2'd2,
        SEND_ACK = 2'd3
    } state_t;

    state_t         state;
    logic [IDW-1:0] grant;
    logic [IDW-1:0] last;

    logic           sel_found;
    logic [IDW-1:0] sel_idx;
    int             cand;

    logic           g_valid;
    logic           g_last;
    logic           g_ack_ready;
    logic           ack_dest_hit;
    logic           ack_capture;

    // Round-robin pick: first requesting index after the last served one.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        for (int k = 1; k <= NUM_ACCS; k++) begin
            cand = int'(last) + k;
            if (cand >= NUM_ACCS) begin
                cand = cand - NUM_ACCS;
            end
            if (!sel_found && in_valid[IDW'(cand)]) begin
                sel_found = 1'b1;
                sel_idx   = IDW'(cand);
            end
        end
    end

    // Steer the granted requester's signals; forwarding is purely combinational.
    always_comb begin
        out_data      = '0;
        g_valid       = 1'b0;
        g_last        = 1'b0;
        g_ack_ready   = 1'b0;
        in_ready      = '0;
        ack_out_valid = '0;
        for (int i = 0; i < NUM_ACCS; i++) begin
            if (grant == IDW'(i)) begin
                out_data         = in_data[i*64 +: 64];
                g_valid          = in_valid[i];
                g_last           = in_last[i];
                g_ack_ready      = ack_out_ready[i];
                in_ready[i]      = (state == FWD) && out_ready;
                ack_out_valid[i] = (state == SEND_ACK);
            end
        end
    end

    assign out_valid    = (state == FWD) && g_valid;
    assign out_last     = g_last;
    assign out_id       = 8'(grant);
    assign ack_in_ready = (state == WAIT_ACK);
    assign ack_dest_hit = (ack_in_dest == 8'(grant));
    assign ack_capture  = (state == WAIT_ACK) && ack_in_valid && ack_dest_hit;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            grant        <= '0;
            last         <= LAST_RST;
            ack_out_data <= '0;
            err          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        grant <= sel_idx;
                        state <= FWD;
                    end
                end
                FWD: begin
                    if (g_valid && out_ready && g_last) begin
                        state <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (ack_in_valid) begin
                        if (ack_dest_hit) begin
                            ack_out_data <= ack_in_data;
                            state        <= SEND_ACK;
                        end else begin
                            // Misrouted ACK is swallowed so the manager cannot stall.
                            err <= 1'b1;
                        end
                    end
                end
                SEND_ACK: begin
                    if (g_ack_ready) begin
                        last  <= grant;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SPAWN_ARB_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stat_ok     <= '0;
            stat_reject <= '0;
            stat_final  <= '0;
        end else if (ack_capture) begin
            if (ack_in_data[7:0] == ACK_OK) begin
                stat_ok <= sat_inc(stat_ok);
            end
            if (ack_in_data[7:0] == ACK_REJECT) begin
                stat_reject <= sat_inc(stat_reject);
            end
            if (ack_in_data[7:0] == ACK_FINAL) begin
                stat_final <= sat_inc(stat_final);
            end
        end
    end
`else
    logic unused_capture;
    assign unused_capture = ack_capture;
`endif

endmodule

// File: tb/tb_spawn_arbiter.sv
// tb/tb_spawn_arbiter.sv - self-checking bench for spawn_arbiter against a packet-level model

module tb_spawn_arbiter;

    localparam int N = 4;
    localparam logic [7:0] C_OK  = 8'h01;
    localparam logic [7:0] C_REJ = 8'h00;
    localparam logic [7:0] C_FIN = 8'h02;

    logic            clk = 1'b0;
    logic            rstn;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic [64*N-1:0] in_data;
    logic [N-1:0]    in_last;
    logic            out_valid;
    logic            out_ready;
    logic [63:0]     out_data;
    logic            out_last;
    logic [7:0]      out_id;
    logic            ack_in_valid;
    logic            ack_in_ready;
    logic [63:0]     ack_in_data;
    logic [7:0]      ack_in_dest;
    logic [N-1:0]    ack_out_valid;
    logic [N-1:0]    ack_out_ready;
    logic [63:0]     ack_out_data;
    logic            err;
`ifdef SPAWN_ARB_STATS_EN
    logic [31:0]     stat_ok, stat_reject, stat_final;
`endif

    always #5 clk = ~clk;

    spawn_arbiter #(.NUM_ACCS(N), .ACK_OK(C_OK), .ACK_REJECT(C_REJ), .ACK_FINAL(C_FIN)) dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_id(out_id),
        .ack_in_valid(ack_in_valid), .ack_in_ready(ack_in_ready),
        .ack_in_data(ack_in_data), .ack_in_dest(ack_in_dest),
        .ack_out_valid(ack_out_valid), .ack_out_ready(ack_out_ready),
        .ack_out_data(ack_out_data), .err(err)
`ifdef SPAWN_ARB_STATS_EN
        , .stat_ok(stat_ok), .stat_reject(stat_reject), .stat_final(stat_final)
`endif
    );

    int tests = 0;
    int fails = 0;

    // Packet-level model: pending packets per requester, the beat each is on,
    // and the index served most recently.
    logic [63:0] pkt [N][8];
    int          len [N];
    int          beat [N];
    bit [N-1:0]  pending;
    int          model_last;
    bit          err_exp;
    int          m_ok, m_rej, m_fin;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_inputs();
        for (int r = 0; r < N; r++) begin
            in_valid[r]         = pending[r];
            in_data[r*64 +: 64] = pkt[r][beat[r]];
            in_last[r]          = (beat[r] == len[r] - 1);
        end
    endtask

    task automatic load(input int r, input int l);
        len[r]  = l;
        beat[r] = 0;
        for (int b = 0; b < 8; b++) pkt[r][b] = {$urandom, $urandom};
        pending[r] = 1'b1;
        drive_inputs();
    endtask

    function automatic int exp_grant();
        for (int k = 1; k <= N; k++) begin
            if (pending[(model_last + k) % N]) return (model_last + k) % N;
        end
        return -1;
    endfunction

    task automatic chk_stats();
`ifdef SPAWN_ARB_STATS_EN
        chk("stat_ok", 64'(stat_ok), 64'(m_ok));
        chk("stat_reject", 64'(stat_reject), 64'(m_rej));
        chk("stat_final", 64'(stat_final), 64'(m_fin));
`endif
    endtask

    // Serve the next packet the model predicts, from IDLE back to IDLE.
    task automatic serve_one(input int stall_at, input bit wrong, input logic [7:0] code);
        int g, cyc, stall_left, d;
        bit gap, hs, done;
        logic [N-1:0] onehot;
        logic [63:0] word;
        g = exp_grant();
        if (g < 0) begin
            tests++; fails++;
            $error("FAIL serve_nothing observed=none expected=pending");
            return;
        end
        onehot = '0;
        onehot[g] = 1'b1;
        @(negedge clk);
        chk("idle_out_valid", out_valid, 0);
        chk("idle_in_ready", in_ready, 0);
        step();
        stall_left = 5; cyc = 0; done = 0;
        while (!done) begin
            if (cyc++ > 300) begin
                tests++; fails++;
                $error("FAIL fwd_timeout observed=beat%0d expected=beat%0d", beat[g], len[g]);
                return;
            end
            if (stall_at >= 0 && beat[g] == stall_at && stall_left > 0) begin
                out_ready = 1'b0; gap = 1'b0; stall_left--;
            end else begin
                out_ready = ($urandom_range(0, 3) != 0);
                gap = ($urandom_range(0, 4) == 0);
            end
            drive_inputs();
            if (gap) in_valid[g] = 1'b0;
            @(negedge clk);
            chk("fwd_out_valid", out_valid, !gap);
            chk("fwd_out_id", out_id, 64'(g));
            chk("fwd_out_data", out_data, pkt[g][beat[g]]);
            chk("fwd_out_last", out_last, beat[g] == len[g] - 1);
            chk("fwd_in_ready", in_ready, out_ready ? onehot : '0);
            hs = !gap && out_ready;
            step();
            if (hs) begin
                beat[g]++;
                if (beat[g] == len[g]) begin
                    done = 1'b1;
                    pending[g] = 1'b0;
                end
            end
        end
        out_ready = 1'b0;
        drive_inputs();
        @(negedge clk);
        chk("wait_ack_in_ready", ack_in_ready, 1);
        chk("wait_out_valid", out_valid, 0);
        chk("wait_in_ready", in_ready, 0);
        chk("wait_ack_out_valid", ack_out_valid, 0);
        step();
        if (wrong) begin
            ack_in_valid = 1'b1;
            ack_in_dest  = 8'((g + 1) % N);
            ack_in_data  = {$urandom, $urandom};
            step();
            ack_in_valid = 1'b0;
            err_exp = 1'b1;
            @(negedge clk);
            chk("wrong_err", err, err_exp);
            chk("wrong_no_delivery", ack_out_valid, 0);
            chk("wrong_still_waiting", ack_in_ready, 1);
            step();
        end
        word = {$urandom, $urandom};
        word[7:0] = code;
        ack_in_valid = 1'b1;
        ack_in_dest  = 8'(g);
        ack_in_data  = word;
        step();
        ack_in_valid = 1'b0;
        ack_in_data  = {$urandom, $urandom};
        ack_out_ready = N'($urandom);
        ack_out_ready[g] = 1'b0;
        if (code == C_OK) m_ok++;
        if (code == C_REJ) m_rej++;
        if (code == C_FIN) m_fin++;
        @(negedge clk);
        chk("ack_out_valid", ack_out_valid, onehot);
        chk("ack_out_data", ack_out_data, word);
        chk("ack_in_ready_low", ack_in_ready, 0);
        chk("ack_err", err, err_exp);
        chk_stats();
        d = $urandom_range(0, 3);
        for (int i = 0; i < d; i++) begin
            step();
            @(negedge clk);
            chk("ack_hold", ack_out_valid, onehot);
        end
        step();
        ack_out_ready[g] = 1'b1;
        @(negedge clk);
        chk("ack_final_valid", ack_out_valid, onehot);
        step();
        ack_out_ready = '0;
        model_last = g;
    endtask

    logic [7:0] codes [4];

    initial begin
        codes = '{C_OK, C_REJ, C_FIN, 8'h5A};
        rstn = 1'b0;
        in_valid = '0; in_data = '0; in_last = '0; out_ready = 1'b0;
        ack_in_valid = 1'b0; ack_in_data = '0; ack_in_dest = '0; ack_out_ready = '0;
        pending = '0; model_last = N - 1; err_exp = 1'b0;
        m_ok = 0; m_rej = 0; m_fin = 0;
        for (int r = 0; r < N; r++) begin
            len[r] = 1; beat[r] = 0;
            for (int b = 0; b < 8; b++) pkt[r][b] = '0;
        end
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_ack_in_ready", ack_in_ready, 0);
        chk("rst_ack_out_valid", ack_out_valid, 0);
        chk("rst_ack_out_data", ack_out_data, 0);
        chk("rst_err", err, 0);
        chk_stats();
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;

        // Requester 0: header, ptid 0x1234, ttype with last; ACK OK.
        load(0, 3);
        pkt[0][1] = 64'h1234;
        drive_inputs();
        serve_one(-1, 1'b0, C_OK);

        // Requesters 1 and 2 together; a misrouted ACK while 1 is granted.
        load(1, $urandom_range(1, 4));
        load(2, $urandom_range(1, 4));
        serve_one(-1, 1'b1, C_OK);
        serve_one(-1, 1'b0, C_FIN);

        // Requester 3 rejected while 0 waits, then resends behind 0.
        load(3, 2);
        load(0, 2);
        serve_one(-1, 1'b0, C_REJ);
        load(3, 2);
        serve_one(-1, 1'b0, C_OK);
        serve_one(-1, 1'b0, C_OK);

        // Five-cycle stall mid-packet, then a single-beat packet.
        load(1, 4);
        serve_one(2, 1'b0, C_OK);
        load(2, 1);
        serve_one(-1, 1'b0, C_FIN);

        // Randomized traffic.
        for (int it = 0; it < 25; it++) begin
            for (int r = 0; r < N; r++) begin
                if (!pending[r] && $urandom_range(0, 1) == 1) load(r, $urandom_range(1, 6));
            end
            if (pending == '0) load($urandom_range(0, N - 1), 1);
            serve_one(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1)) : -1,
                      $urandom_range(0, 4) == 0, codes[$urandom_range(0, 3)]);
        end
        for (int k = 0; k < N && pending != '0; k++) serve_one(-1, 1'b0, C_OK);

        // Reset during the second beat of a packet.
        load(1, 4);
        load(3, 2);
        begin
            int g;
            g = exp_grant();
            @(negedge clk);
            step();
            out_ready = 1'b1;
            drive_inputs();
            @(negedge clk);
            chk("pre_rst_out_id", out_id, 64'(g));
            step();
            #2;
            rstn = 1'b0;
            #1;
            chk("midrst_out_valid", out_valid, 0);
            chk("midrst_in_ready", in_ready, 0);
            chk("midrst_ack_in_ready", ack_in_ready, 0);
            chk("midrst_ack_out_valid", ack_out_valid, 0);
            chk("midrst_err", err, 0);
            chk("midrst_ack_out_data", ack_out_data, 0);
            beat[g] = 0;
        end
        out_ready = 1'b0;
        model_last = N - 1; err_exp = 1'b0;
        m_ok = 0; m_rej = 0; m_fin = 0;
        @(negedge clk);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        load(0, 2);
        serve_one(-1, 1'b0, C_OK);
        serve_one(-1, 1'b0, C_REJ);
        serve_one(-1, 1'b0, C_OK);
        chk("drained", 64'(pending), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $error("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
